mem_access_unit: RTL and testbench

MEM-stage data-memory access unit sitting directly downstream of the EX/MEM pipeline register. Takes the registered memory controls, ALU address, store data and FUNC3, performs RV32 load/store sizing, lane alignment, byte enables and sign/zero extension, and runs a request/busywait handshake with the data memory. Drives BUSYWAIT back to the pipeline registers to freeze the pipeline until the access completes. Also flags misaligned, illegal-size and timed-out accesses.

---
 rtl/mem_access_if.sv | 31 +++
 rtl/mem_access_unit.sv | 170 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// MEM-stage bundle: pipeline-side controls and data plus the data-memory request/busywait bus.
interface mem_access_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] aluud;
  logic [31:0] data2;
  logic [2:0]  func3;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_writedata;
  logic [3:0]  dmem_byte_en;
  logic [31:0] dmem_readdata;
  logic        dmem_busywait;
  logic        busywait;
  logic [31:0] load_data;
  logic        mem_fault;
  logic [1:0]  fault_cause;

  modport slave (
    input  mem_read, mem_write, aluud, data2, func3, dmem_readdata, dmem_busywait,
    output dmem_read, dmem_write, dmem_address, dmem_writedata, dmem_byte_en,
           busywait, load_data, mem_fault, fault_cause
  );

  modport master (
    output mem_read, mem_write, aluud, data2, func3, dmem_readdata, dmem_busywait,
    input  dmem_read, dmem_write, dmem_address, dmem_writedata, dmem_byte_en,
           busywait, load_data, mem_fault, fault_cause
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV32 MEM-stage access unit: sizing, lane alignment, extension, busywait handshake and
// misaligned / illegal / timeout fault reporting.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_access_if.slave  bus
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] load_q, load_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;

  logic        is_req, legal, misaligned, busywait;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Request decode: legality, alignment and store lane placement.
  always_comb begin
    is_req = bus.mem_read | bus.mem_write;
    if (bus.mem_write) legal = bus.func3 inside {3'b000, 3'b001, 3'b010};
    else               legal = bus.func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    misaligned = 1'b0;
    st_data    = bus.data2;
    st_be      = 4'b1111;
    case (bus.func3[1:0])
      2'b00: begin
        st_data = {4{bus.data2[7:0]}};
        st_be   = 4'b0001 << bus.aluud[1:0];
      end
      2'b01: begin
        misaligned = bus.aluud[0];
        st_data    = {2{bus.data2[15:0]}};
        st_be      = bus.aluud[1] ? 4'b1100 : 4'b0011;
      end
      default: misaligned = |bus.aluud[1:0];
    endcase
  end

  // Load extraction uses the lane and size captured at request time.
  always_comb begin
    ld_byte = bus.dmem_readdata[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? bus.dmem_readdata[31:16] : bus.dmem_readdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = bus.dmem_readdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    lane_d   = lane_q;
    f3_d     = f3_q;
    load_d   = load_q;
    fault_d  = 1'b0;
    cause_d  = cause_q;
    busywait = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (is_req) begin
          if (!legal) begin
            fault_d = 1'b1;
            cause_d = 2'b10;
          end else if (misaligned) begin
            fault_d = 1'b1;
            cause_d = 2'b01;
          end else begin
            busywait = 1'b1;
            rd_d     = ~bus.mem_write;
            wr_d     = bus.mem_write;
            addr_d   = {bus.aluud[31:2], 2'b00};
            be_d     = bus.mem_write ? st_be : 4'b0000;
            wdata_d  = bus.mem_write ? st_data : 32'h0;
            lane_d   = bus.aluud[1:0];
            f3_d     = bus.func3;
            cnt_d    = 8'd0;
            state_d  = StAccess;
          end
        end
      end
      StAccess: begin
        busywait = 1'b1;
        cnt_d    = cnt_q + 8'd1;
        // The memory's busywait is not yet meaningful in the first ACCESS cycle.
        if (cnt_q != 8'd0 && !bus.dmem_busywait) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (rd_q) load_d = ld_ext;
          state_d = StDone;
        end else if (cnt_q == TimeoutLast) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          fault_d = 1'b1;
          cause_d = 2'b11;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'b0000;
      lane_q  <= 2'b00;
      f3_q    <= 3'b000;
      load_q  <= 32'h0;
      fault_q <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      lane_q  <= lane_d;
      f3_q    <= f3_d;
      load_q  <= load_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
    end
  end

  assign bus.dmem_read      = rd_q;
  assign bus.dmem_write     = wr_q;
  assign bus.dmem_address   = addr_q;
  assign bus.dmem_writedata = wdata_q;
  assign bus.dmem_byte_en   = be_q;
  assign bus.busywait       = busywait;
  assign bus.load_data      = load_q;
  assign bus.mem_fault      = fault_q;
  assign bus.fault_cause    = cause_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset-in-access sequence and randomized
// transactions against a transaction-level model.
module tb_mem_access_unit;

  localparam int To = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_if mif();

  mem_access_unit #(.TIMEOUT_CYCLES(To)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (mif)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d2;
    logic [31:0] rdat;
    int          nb;
  } req_t;

  typedef struct {
    int          busy;
    logic        srd;
    logic        swr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          faults;
    logic [1:0]  cause;
    logic [31:0] ld;
  } res_t;

  typedef struct {
    req_t r;
    res_t e;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] ld_m = 32'h0;
  logic [1:0]  cause_m = 2'b00;
  vec_t        tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: latency, lanes and held outputs derived from the access rules.
  task automatic predict(input req_t r, output res_t e);
    int          size;
    int          acc;
    logic        legal;
    logic [31:0] w;
    e = '{default: 0};
    if (r.rd || r.wr) begin
      legal = r.wr ? (r.f3 <= 3'd2) : (r.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      size  = 1 << r.f3[1:0];
      if (!legal) begin
        e.faults = 1; cause_m = 2'b10;
      end else if ((int'(r.a[1:0]) % size) != 0) begin
        e.faults = 1; cause_m = 2'b01;
      end else begin
        acc   = ((r.nb < 1) ? 1 : r.nb) + 1;
        e.srd = !r.wr;
        e.swr = r.wr;
        e.addr = r.a & ~32'h3;
        if (r.wr) begin
          if (size == 1) begin
            e.wd = {4{r.d2[7:0]}}; e.be = 4'(1 << r.a[1:0]);
          end else if (size == 2) begin
            e.wd = {2{r.d2[15:0]}}; e.be = 4'(3 << (2 * r.a[1]));
          end else begin
            e.wd = r.d2; e.be = 4'hF;
          end
        end
        if (acc > To) begin
          e.busy = To + 1; e.faults = 1; cause_m = 2'b11;
        end else begin
          e.busy = acc + 1;
          if (!r.wr) begin
            w = r.rdat >> (8 * r.a[1:0]);
            if (size == 1)      ld_m = r.f3[2] ? (w & 32'hFF) : {{24{w[7]}}, w[7:0]};
            else if (size == 2) ld_m = r.f3[2] ? (w & 32'hFFFF) : {{16{w[15]}}, w[15:0]};
            else                ld_m = w;
          end
        end
      end
    end
    e.ld    = ld_m;
    e.cause = cause_m;
  endtask

  task automatic run_txn(input req_t r, output res_t o, output bit unst, output bit hung);
    bit fin = 0;
    bit seen = 0;
    o = '{default: 0};
    unst = 0;
    @(posedge clk); #1;
    mif.mem_read = r.rd; mif.mem_write = r.wr; mif.func3 = r.f3;
    mif.aluud = r.a; mif.data2 = r.d2; mif.dmem_readdata = r.rdat;
    for (int k = 0; k < 40 && !fin; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      mif.dmem_busywait = (k >= 1 && k <= r.nb);
      @(negedge clk);
      if (mif.busywait) o.busy++;
      if (mif.mem_fault) o.faults++;
      if (mif.dmem_read) o.srd = 1'b1;
      if (mif.dmem_write) o.swr = 1'b1;
      if (mif.dmem_read || mif.dmem_write) begin
        if (!seen) begin
          o.addr = mif.dmem_address; o.be = mif.dmem_byte_en; o.wd = mif.dmem_writedata;
          seen = 1;
        end else if (o.addr !== mif.dmem_address || o.be !== mif.dmem_byte_en ||
                     o.wd !== mif.dmem_writedata) begin
          unst = 1;
        end
      end
      if (!mif.busywait) begin
        fin  = 1;
        o.ld = mif.load_data;
      end
    end
    hung = !fin;
    @(posedge clk); #1;
    mif.mem_read = 1'b0; mif.mem_write = 1'b0; mif.dmem_busywait = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (mif.mem_fault) o.faults++;
    end
    o.cause = mif.fault_cause;
  endtask

  task automatic compare(input string tag, input res_t e, input res_t o, input bit unst,
                         input bit hung);
    check({tag, " hang"}, 32'(hung), 32'h0);
    check({tag, " busy"}, o.busy, e.busy);
    check({tag, " rd"}, 32'(o.srd), 32'(e.srd));
    check({tag, " wr"}, 32'(o.swr), 32'(e.swr));
    check({tag, " faults"}, o.faults, e.faults);
    check({tag, " cause"}, 32'(o.cause), 32'(e.cause));
    check({tag, " load"}, o.ld, e.ld);
    if (e.srd || e.swr) begin
      check({tag, " addr"}, o.addr, e.addr);
      check({tag, " stable"}, 32'(unst), 32'h0);
    end
    if (e.swr) begin
      check({tag, " be"}, 32'(o.be), 32'(e.be));
      check({tag, " wdata"}, o.wd, e.wd);
    end
  endtask

  task automatic add_vec(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d2, input logic [31:0] rdat,
                         input int nb, input int busy, input logic srd, input logic swr,
                         input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                         input int faults, input logic [1:0] cause, input logic [31:0] ld);
    vec_t v;
    v.r = '{rd, wr, f3, a, d2, rdat, nb};
    v.e = '{busy, srd, swr, addr, be, wd, faults, cause, ld};
    tbl.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req_t r;
    res_t e, o, dummy;
    bit   unst, hung;
    int   sel;

    //       rd wr f3    addr     d2           rdat         nb busy srd swr addr     be    wd           flt cause ld
    add_vec(1, 0, 3'd2, 32'h100, 32'h0,       32'hDEADBEEF, 2, 4, 1, 0, 32'h100, 4'h0, 32'h0,       0, 2'd0, 32'hDEADBEEF);
    add_vec(1, 0, 3'd0, 32'h203, 32'h0,       32'h80FF0000, 1, 3, 1, 0, 32'h200, 4'h0, 32'h0,       0, 2'd0, 32'hFFFFFF80);
    add_vec(1, 0, 3'd4, 32'h203, 32'h0,       32'h80FF0000, 0, 3, 1, 0, 32'h200, 4'h0, 32'h0,       0, 2'd0, 32'h00000080);
    add_vec(0, 1, 3'd0, 32'h001, 32'h12345678, 32'h0,       1, 3, 0, 1, 32'h000, 4'h2, 32'h78787878, 0, 2'd0, 32'h00000080);
    add_vec(0, 1, 3'd1, 32'h002, 32'h12345678, 32'h0,       2, 4, 0, 1, 32'h000, 4'hC, 32'h56785678, 0, 2'd0, 32'h00000080);
    add_vec(1, 0, 3'd1, 32'h101, 32'h0,       32'h0,        1, 0, 0, 0, 32'h0,   4'h0, 32'h0,       1, 2'd1, 32'h00000080);
    add_vec(0, 1, 3'd6, 32'h001, 32'h0,       32'h0,        1, 0, 0, 0, 32'h0,   4'h0, 32'h0,       1, 2'd2, 32'h00000080);
    add_vec(0, 1, 3'd2, 32'h102, 32'h0,       32'h0,        1, 0, 0, 0, 32'h0,   4'h0, 32'h0,       1, 2'd1, 32'h00000080);
    add_vec(1, 0, 3'd3, 32'h100, 32'h0,       32'h0,        1, 0, 0, 0, 32'h0,   4'h0, 32'h0,       1, 2'd2, 32'h00000080);
    add_vec(1, 0, 3'd5, 32'h302, 32'h0,       32'h80011234, 1, 3, 1, 0, 32'h300, 4'h0, 32'h0,       0, 2'd2, 32'h00008001);
    add_vec(1, 0, 3'd1, 32'h302, 32'h0,       32'h80011234, 2, 4, 1, 0, 32'h300, 4'h0, 32'h0,       0, 2'd2, 32'hFFFF8001);
    add_vec(0, 1, 3'd2, 32'h40C, 32'hCAFEF00D, 32'h0,       0, 3, 0, 1, 32'h40C, 4'hF, 32'hCAFEF00D, 0, 2'd2, 32'hFFFF8001);
    add_vec(1, 1, 3'd2, 32'h010, 32'hA5A50F0F, 32'h0,       1, 3, 0, 1, 32'h010, 4'hF, 32'hA5A50F0F, 0, 2'd2, 32'hFFFF8001);
    add_vec(1, 0, 3'd2, 32'h500, 32'h0,       32'h11111111, 50, 5, 1, 0, 32'h500, 4'h0, 32'h0,      1, 2'd3, 32'hFFFF8001);
    add_vec(1, 0, 3'd2, 32'h504, 32'h0,       32'h11111111, 1, 3, 1, 0, 32'h504, 4'h0, 32'h0,       0, 2'd3, 32'h11111111);
    add_vec(0, 0, 3'd2, 32'h504, 32'h0,       32'h0,        1, 0, 0, 0, 32'h0,   4'h0, 32'h0,       0, 2'd3, 32'h11111111);

    mif.mem_read = 1'b0; mif.mem_write = 1'b0; mif.func3 = 3'd0; mif.aluud = 32'h0;
    mif.data2 = 32'h0; mif.dmem_readdata = 32'h0; mif.dmem_busywait = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset dmem_read", 32'(mif.dmem_read), 32'h0);
    check("reset dmem_write", 32'(mif.dmem_write), 32'h0);
    check("reset address", mif.dmem_address, 32'h0);
    check("reset writedata", mif.dmem_writedata, 32'h0);
    check("reset byte_en", 32'(mif.dmem_byte_en), 32'h0);
    check("reset load_data", mif.load_data, 32'h0);
    check("reset mem_fault", 32'(mif.mem_fault), 32'h0);
    check("reset cause", 32'(mif.fault_cause), 32'h0);
    check("reset busywait", 32'(mif.busywait), 32'h0);

    foreach (tbl[i]) begin
      predict(tbl[i].r, dummy);
      run_txn(tbl[i].r, o, unst, hung);
      compare($sformatf("vec%0d", i), tbl[i].e, o, unst, hung);
    end

    // Reset during the second ACCESS cycle of a store.
    @(posedge clk); #1;
    mif.mem_read = 1'b0; mif.mem_write = 1'b1; mif.func3 = 3'd2;
    mif.aluud = 32'h60; mif.data2 = 32'h01020304; mif.dmem_busywait = 1'b0;
    @(posedge clk); #1 mif.dmem_busywait = 1'b1;
    @(posedge clk); #1;
    check("rst-mid write strobe", 32'(mif.dmem_write), 32'h1);
    rst = 1'b1; mif.mem_write = 1'b0;
    @(posedge clk); #1 rst = 1'b0; mif.dmem_busywait = 1'b0;
    @(negedge clk);
    check("rst-mid write dropped", 32'(mif.dmem_write), 32'h0);
    check("rst-mid busywait", 32'(mif.busywait), 32'h0);
    check("rst-mid address", mif.dmem_address, 32'h0);
    check("rst-mid load_data", mif.load_data, 32'h0);
    ld_m = 32'h0;
    cause_m = 2'b00;
    r = '{1'b1, 1'b0, 3'd2, 32'h80, 32'h0, 32'h5A5AC3C3, 1};
    predict(r, e);
    run_txn(r, o, unst, hung);
    compare("post-reset LW", e, o, unst, hung);

    for (int n = 0; n < 300; n++) begin
      sel  = $urandom_range(0, 7);
      r.rd = (sel >= 1 && sel <= 3) || sel == 7;
      r.wr = sel >= 4;
      r.f3 = 3'($urandom_range(0, 7));
      r.a  = $urandom;
      if ($urandom_range(0, 1) == 1) r.a = r.a & ~((32'h1 << r.f3[1:0]) - 32'h1);
      r.d2   = $urandom;
      r.rdat = $urandom;
      r.nb   = ($urandom_range(0, 15) == 0) ? 20 : $urandom_range(0, 2);
      predict(r, e);
      run_txn(r, o, unst, hung);
      compare($sformatf("rnd%0d", n), e, o, unst, hung);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
